// File: rtl/gfx_pkg.sv
// Shared types and constants for the fixed-point graphics pipeline.
package gfx_pkg;

   // Signed world/camera-space coordinate.
   typedef logic signed [31:0] coord_t;

   // Signed Q1.14 sine/cosine value.
   typedef logic signed [15:0] trig_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
      coord_t z;
   } vec3_t;

   // 1.0 in Q1.14.
   localparam int TRIG_ONE = 16384;

endpackage

// File: rtl/rot2d.sv
// Registered 2-D rotation: (a*cos - b*sin, a*sin + b*cos) >>> TRIG_FRAC.
// Products are 48-bit, sums 49-bit, results wrap to 32 bits.
module rot2d
   import gfx_pkg::*;
#(
   parameter int unsigned TRIG_FRAC = 14
) (
   input  logic   i_clk,
   input  logic   i_rst_n,
   input  logic   i_en,
   input  coord_t i_a,
   input  coord_t i_b,
   input  trig_t  i_sin,
   input  trig_t  i_cos,
   output coord_t o_p,
   output coord_t o_q
);

   logic signed [47:0] w_a_cos;
   logic signed [47:0] w_b_sin;
   logic signed [47:0] w_a_sin;
   logic signed [47:0] w_b_cos;
   logic signed [48:0] w_p_sum;
   logic signed [48:0] w_q_sum;
   coord_t             r_p;
   coord_t             r_q;

   assign w_a_cos = 48'(i_a) * 48'(i_cos);
   assign w_b_sin = 48'(i_b) * 48'(i_sin);
   assign w_a_sin = 48'(i_a) * 48'(i_sin);
   assign w_b_cos = 48'(i_b) * 48'(i_cos);

   assign w_p_sum = 49'(w_a_cos) - 49'(w_b_sin);
   assign w_q_sum = 49'(w_a_sin) + 49'(w_b_cos);

   // Capture the rotated pair; arithmetic shift floors toward -inf.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_p <= '0;
         r_q <= '0;
      end else if (i_en) begin
         r_p <= 32'(w_p_sum >>> TRIG_FRAC);
         r_q <= 32'(w_q_sum >>> TRIG_FRAC);
      end
   end

   assign o_p = r_p;
   assign o_q = r_q;

endmodule

// File: rtl/view_transformation.sv
// World-to-camera vertex transform: translate, yaw, pitch, near-plane flag.
// Three-stage pipeline with a single global stall driven by out_ready.
module view_transformation
   import gfx_pkg::*;
#(
   parameter int unsigned TRIG_FRAC = 14,
   parameter int          NEAR      = 1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             FRAME_START,
   input  logic             in_valid,
   output logic             in_ready,
   input  coord_t           wx,
   input  coord_t           wy,
   input  coord_t           wz,
   input  coord_t           cam_x,
   input  coord_t           cam_y,
   input  coord_t           cam_z,
   input  trig_t            sin_yaw,
   input  trig_t            cos_yaw,
   input  trig_t            sin_pitch,
   input  trig_t            cos_pitch,
   output logic             out_valid,
   input  logic             out_ready,
   output coord_t           vx,
   output coord_t           vy,
   output coord_t           vz,
   output logic             behind,
   output logic [CNT_W-1:0] vert_count,
   output logic [CNT_W-1:0] cull_count
);

   logic             w_en;
   logic             w_out_xfer;
   coord_t           w_x1;
   coord_t           w_z1;
   coord_t           w_vy;
   coord_t           w_vz;
   logic [CNT_W-1:0] w_vert_base;
   logic [CNT_W-1:0] w_cull_base;
   logic [CNT_W-1:0] w_vert_next;
   logic [CNT_W-1:0] w_cull_next;

   // Stage 1: translated vertex plus the trig values travelling with it.
   logic   r_s1_valid;
   vec3_t  r_d;
   trig_t  r_s1_sin_yaw;
   trig_t  r_s1_cos_yaw;
   trig_t  r_s1_sin_pitch;
   trig_t  r_s1_cos_pitch;

   // Stage 2: yaw result lives in the rot2d instance; y and pitch trig ride along.
   logic   r_s2_valid;
   coord_t r_y1;
   trig_t  r_s2_sin_pitch;
   trig_t  r_s2_cos_pitch;

   // Stage 3: output stage; vy/vz live in the pitch rot2d instance.
   logic   r_s3_valid;
   coord_t r_vx;

   logic [CNT_W-1:0] r_vert_count;
   logic [CNT_W-1:0] r_cull_count;

   // An empty output stage never blocks, so bubbles are squeezed out.
   assign w_en       = !r_s3_valid || out_ready;
   assign w_out_xfer = r_s3_valid && out_ready;

   // Stage 1: subtract camera position and sample the trig inputs.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_s1_valid     <= 1'b0;
         r_d            <= '0;
         r_s1_sin_yaw   <= '0;
         r_s1_cos_yaw   <= '0;
         r_s1_sin_pitch <= '0;
         r_s1_cos_pitch <= '0;
      end else if (w_en) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_d.x          <= wx - cam_x;
            r_d.y          <= wy - cam_y;
            r_d.z          <= wz - cam_z;
            r_s1_sin_yaw   <= sin_yaw;
            r_s1_cos_yaw   <= cos_yaw;
            r_s1_sin_pitch <= sin_pitch;
            r_s1_cos_pitch <= cos_pitch;
         end
      end
   end

   rot2d #(
      .TRIG_FRAC (TRIG_FRAC)
   ) u_yaw (
      .i_clk   (CLK),
      .i_rst_n (RESET_N),
      .i_en    (w_en && r_s1_valid),
      .i_a     (r_d.x),
      .i_b     (r_d.z),
      .i_sin   (r_s1_sin_yaw),
      .i_cos   (r_s1_cos_yaw),
      .o_p     (w_x1),
      .o_q     (w_z1)
   );

   // Stage 2: carry y and the pitch trig alongside the yaw rotation.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_s2_valid     <= 1'b0;
         r_y1           <= '0;
         r_s2_sin_pitch <= '0;
         r_s2_cos_pitch <= '0;
      end else if (w_en) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_y1           <= r_d.y;
            r_s2_sin_pitch <= r_s1_sin_pitch;
            r_s2_cos_pitch <= r_s1_cos_pitch;
         end
      end
   end

   rot2d #(
      .TRIG_FRAC (TRIG_FRAC)
   ) u_pitch (
      .i_clk   (CLK),
      .i_rst_n (RESET_N),
      .i_en    (w_en && r_s2_valid),
      .i_a     (r_y1),
      .i_b     (w_z1),
      .i_sin   (r_s2_sin_pitch),
      .i_cos   (r_s2_cos_pitch),
      .o_p     (w_vy),
      .o_q     (w_vz)
   );

   // Stage 3: output valid and the unrotated x.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_s3_valid <= 1'b0;
         r_vx       <= '0;
      end else if (w_en) begin
         r_s3_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_vx <= w_x1;
         end
      end
   end

   // Counter next state: frame clear first, then a saturating increment.
   always_comb begin
      w_vert_base = FRAME_START ? '0 : r_vert_count;
      w_cull_base = FRAME_START ? '0 : r_cull_count;
      w_vert_next = w_vert_base;
      w_cull_next = w_cull_base;
      if (w_out_xfer && (w_vert_base != '1)) begin
         w_vert_next = w_vert_base + CNT_W'(1);
      end
      if (w_out_xfer && behind && (w_cull_base != '1)) begin
         w_cull_next = w_cull_base + CNT_W'(1);
      end
   end

   // Per-frame statistics registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_vert_count <= '0;
         r_cull_count <= '0;
      end else begin
         r_vert_count <= w_vert_next;
         r_cull_count <= w_cull_next;
      end
   end

   assign in_ready   = w_en;
   assign out_valid  = r_s3_valid;
   assign vx         = r_vx;
   assign vy         = w_vy;
   assign vz         = w_vz;
   // Gated by valid so the reset value of vz (0) does not raise the flag.
   assign behind     = r_s3_valid && (w_vz < NEAR);
   assign vert_count = r_vert_count;
   assign cull_count = r_cull_count;

endmodule

// File: tb/tb_view_transformation.sv
// Bench for view_transformation: directed cases plus randomized traffic
// checked against a plain-arithmetic reference model and scoreboard queue.
module tb_view_transformation;
   import gfx_pkg::*;

   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;
   localparam int FRAC = 14;

   typedef struct {
      int wx, wy, wz, cx, cy, cz;
      int sy, cyw, sp, cp;
   } stim_t;

   typedef struct {
      int vx, vy, vz;
      bit bh;
   } exp_t;

   logic          CLK;
   logic          RESET_N;
   logic          FRAME_START;
   logic          in_valid;
   logic          in_ready;
   coord_t        wx, wy, wz, cam_x, cam_y, cam_z;
   trig_t         sin_yaw, cos_yaw, sin_pitch, cos_pitch;
   logic          out_valid;
   logic          out_ready;
   coord_t        vx, vy, vz;
   logic          behind;
   logic [CW-1:0] vert_count;
   logic [CW-1:0] cull_count;

   int n_cmp = 0;
   int n_bad = 0;

   exp_t exp_q[$];
   exp_t mon_e;
   bit   mon_bh;
   int   m_vert;
   int   m_cull;

   view_transformation #(
      .TRIG_FRAC (14),
      .NEAR      (1),
      .CNT_W     (CW)
   ) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .FRAME_START (FRAME_START),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .wx          (wx),
      .wy          (wy),
      .wz          (wz),
      .cam_x       (cam_x),
      .cam_y       (cam_y),
      .cam_z       (cam_z),
      .sin_yaw     (sin_yaw),
      .cos_yaw     (cos_yaw),
      .sin_pitch   (sin_pitch),
      .cos_pitch   (cos_pitch),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .vx          (vx),
      .vy          (vy),
      .vz          (vz),
      .behind      (behind),
      .vert_count  (vert_count),
      .cull_count  (cull_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   // Camera transform straight from the arithmetic definition, in 64-bit math.
   function automatic exp_t ref_model(input stim_t s);
      exp_t   e;
      int     dx, dy, dz, x1, z1;
      longint t;
      dx = s.wx - s.cx;
      dy = s.wy - s.cy;
      dz = s.wz - s.cz;
      t  = (longint'(dx) * longint'(s.cyw) - longint'(dz) * longint'(s.sy)) >>> FRAC;
      x1 = int'(t);
      t  = (longint'(dx) * longint'(s.sy) + longint'(dz) * longint'(s.cyw)) >>> FRAC;
      z1 = int'(t);
      t  = (longint'(dy) * longint'(s.cp) - longint'(z1) * longint'(s.sp)) >>> FRAC;
      e.vy = int'(t);
      t  = (longint'(dy) * longint'(s.sp) + longint'(z1) * longint'(s.cp)) >>> FRAC;
      e.vz = int'(t);
      e.vx = x1;
      e.bh = (e.vz < 1);
      return e;
   endfunction

   function automatic stim_t mk(input int a, input int b, input int c, input int d,
                                input int e, input int f, input int g, input int h,
                                input int i, input int j);
      stim_t s;
      s.wx = a; s.wy = b; s.wz = c; s.cx = d; s.cy = e; s.cz = f;
      s.sy = g; s.cyw = h; s.sp = i; s.cp = j;
      return s;
   endfunction

   function automatic int rcoord();
      return int'($urandom_range(0, 8388608)) - 4194304;
   endfunction

   function automatic int rtrig();
      return int'($urandom_range(0, 32768)) - 16384;
   endfunction

   function automatic stim_t rand_stim();
      return mk(rcoord(), rcoord(), rcoord(), rcoord(), rcoord(), rcoord(),
                rtrig(), rtrig(), rtrig(), rtrig());
   endfunction

   task automatic apply(input stim_t s);
      wx        = s.wx;
      wy        = s.wy;
      wz        = s.wz;
      cam_x     = s.cx;
      cam_y     = s.cy;
      cam_z     = s.cz;
      sin_yaw   = 16'(s.sy);
      cos_yaw   = 16'(s.cyw);
      sin_pitch = 16'(s.sp);
      cos_pitch = 16'(s.cp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Scoreboard and counter model, sampled mid-cycle.
   always @(negedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         exp_q.delete();
         m_vert = 0;
         m_cull = 0;
      end else begin
         chk("vert_count", vert_count, m_vert);
         chk("cull_count", cull_count, m_cull);
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_model(mk(wx, wy, wz, cam_x, cam_y, cam_z,
                                         sin_yaw, cos_yaw, sin_pitch, cos_pitch)));
         end
         mon_bh = 1'b0;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out", 1, 0);
            end else begin
               mon_e  = exp_q.pop_front();
               mon_bh = mon_e.bh;
               chk("sb_vx", vx, mon_e.vx);
               chk("sb_vy", vy, mon_e.vy);
               chk("sb_vz", vz, mon_e.vz);
               chk("sb_behind", behind, mon_e.bh);
            end
         end
         if (FRAME_START) begin
            m_vert = 0;
            m_cull = 0;
         end
         if (out_valid && out_ready) begin
            if (m_vert < CMAX) m_vert++;
            if (mon_bh && m_cull < CMAX) m_cull++;
         end
      end
   end

   // One vertex into an idle pipeline; checks 3-cycle latency and the result.
   task automatic send1(input string tag, input stim_t s, input int ex, input int ey,
                        input int ez, input bit eb);
      apply(s);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk({tag, "_lat1"}, out_valid, 0);
      tick();
      chk({tag, "_lat2"}, out_valid, 0);
      tick();
      chk({tag, "_lat3"}, out_valid, 1);
      chk({tag, "_vx"}, vx, ex);
      chk({tag, "_vy"}, vy, ey);
      chk({tag, "_vz"}, vz, ez);
      chk({tag, "_behind"}, behind, eb);
   endtask

   stim_t bp[8];
   stim_t pend;
   bit    took;
   bit    have;
   int    sent, stalls, guard;
   coord_t sx, sy, sz;

   initial begin
      RESET_N     = 1'b0;
      FRAME_START = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      apply(mk(0, 0, 0, 0, 0, 0, 0, TRIG_ONE, 0, TRIG_ONE));
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_vx", vx, 0);
      chk("rst_vy", vy, 0);
      chk("rst_vz", vz, 0);
      chk("rst_behind", behind, 0);
      chk("rst_vert", vert_count, 0);
      chk("rst_cull", cull_count, 0);
      tick();
      RESET_N = 1'b1;
      chk("rst_in_ready", in_ready, 1);
      tick();

      send1("ident", mk(100, 50, 200, 0, 0, 0, 0, TRIG_ONE, 0, TRIG_ONE), 100, 50, 200, 0);
      send1("trans", mk(10, 20, 130, 10, 20, 30, 0, TRIG_ONE, 0, TRIG_ONE), 0, 0, 100, 0);
      send1("yaw90", mk(100, 0, 0, 0, 0, 0, TRIG_ONE, 0, 0, TRIG_ONE), 0, 0, 100, 0);
      send1("pitch90", mk(0, 100, 0, 0, 0, 0, 0, TRIG_ONE, TRIG_ONE, 0), 0, 0, 100, 0);

      // Frame clear coinciding with a transfer leaves exactly that vertex counted.
      FRAME_START = 1'b1;
      tick();
      FRAME_START = 1'b0;
      chk("fs_xfer_vert", vert_count, 1);
      chk("fs_xfer_cull", cull_count, 0);
      FRAME_START = 1'b1;
      tick();
      FRAME_START = 1'b0;
      chk("fs_clr_vert", vert_count, 0);

      send1("near0", mk(0, 0, 0, 0, 0, 0, 0, TRIG_ONE, 0, TRIG_ONE), 0, 0, 0, 1);
      send1("near5", mk(0, 0, 5, 0, 0, 0, 0, TRIG_ONE, 0, TRIG_ONE), 0, 0, 5, 0);
      send1("nearm3", mk(0, 0, -3, 0, 0, 0, 0, TRIG_ONE, 0, TRIG_ONE), 0, 0, -3, 1);
      tick();
      chk("near_vert", vert_count, 3);
      chk("near_cull", cull_count, 2);
      FRAME_START = 1'b1;
      tick();
      FRAME_START = 1'b0;
      chk("near_clr_vert", vert_count, 0);
      chk("near_clr_cull", cull_count, 0);

      // Backpressure: stall 5 cycles from the first out_valid.
      for (int i = 0; i < 8; i++) bp[i] = rand_stim();
      sent   = 0;
      stalls = 0;
      guard  = 0;
      while ((sent < 8 || exp_q.size() != 0) && guard < 200) begin
         guard++;
         if (out_valid && stalls < 5) begin
            out_ready = 1'b0;
            if (stalls == 0) begin
               sx = vx; sy = vy; sz = vz;
            end else begin
               chk("bp_hold_valid", out_valid, 1);
               chk("bp_hold_vx", vx, sx);
               chk("bp_hold_vy", vy, sy);
               chk("bp_hold_vz", vz, sz);
            end
            stalls++;
         end else begin
            out_ready = 1'b1;
         end
         if (sent < 8) begin
            apply(bp[sent]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge CLK);
         if (!out_ready) chk("bp_in_ready", in_ready, 0);
         took = in_valid && in_ready;
         tick();
         if (took) sent++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_drained", (sent == 8 && exp_q.size() == 0 && stalls == 5), 1);

      // Random traffic with random backpressure and occasional frame clears.
      have = 1'b0;
      for (int c = 0; c < 500; c++) begin
         out_ready   = ($urandom_range(0, 3) != 0);
         FRAME_START = ($urandom_range(0, 59) == 0);
         if (!have && $urandom_range(0, 3) != 0) begin
            pend = rand_stim();
            have = 1'b1;
         end
         if (have) apply(pend);
         in_valid = have;
         @(negedge CLK);
         took = in_valid && in_ready;
         tick();
         if (took) have = 1'b0;
      end
      in_valid    = 1'b0;
      FRAME_START = 1'b0;
      out_ready   = 1'b1;
      guard       = 0;
      while ((exp_q.size() != 0 || out_valid) && guard < 20) begin
         guard++;
         tick();
      end
      chk("rand_drained", exp_q.size(), 0);

      // Reset with three vertices in flight.
      FRAME_START = 1'b0;
      for (int i = 0; i < 3; i++) begin
         apply(rand_stim());
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      chk("pre_rst_valid", out_valid, 1);
      #1;
      RESET_N = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_vx", vx, 0);
      chk("mid_rst_behind", behind, 0);
      chk("mid_rst_vert", vert_count, 0);
      chk("mid_rst_cull", cull_count, 0);
      tick();
      RESET_N = 1'b1;
      tick();
      send1("post_rst", mk(7, 8, 9, 0, 0, 0, 0, TRIG_ONE, 0, TRIG_ONE), 7, 8, 9, 0);
      tick();
      chk("post_rst_vert", vert_count, 1);
      chk("final_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/view_transformation.md
# view_transformation

Pipelined world-to-camera vertex transform that sits directly upstream of the perspective projection stage. It accepts one world-space vertex per cycle and subtracts the camera position. It then applies yaw (about Y) and pitch (about X) rotations using fixed-point sin/cos inputs. It emits camera-space x/y/z (32-bit signed) through a valid/ready handshake. It also flags vertices at or behind the near plane, so the projection stage never divides by a non-positive z.

## Interface
Parameters:
- TRIG_FRAC, 14: fractional bits of the sin/cos inputs (Q1.14).
- NEAR, 1: minimum camera-space z treated as visible. A vertex with z < NEAR is flagged behind.
- CNT_W, 16: width of the per-frame statistics counters.

Ports:
- CLK  in  1  the single clock; all logic on posedge.
- RESET_N  in  1  reset; asynchronous, active-low.
- FRAME_START  in  1  single-cycle pulse that clears the statistics counters.
- in_valid  in  1  a world vertex is presented.
- in_ready  out  1  the stage accepts the vertex this cycle.
- wx, wy, wz  in  32 each  world coordinates, signed.
- cam_x, cam_y, cam_z  in  32 each  camera position, signed.
- sin_yaw, cos_yaw, sin_pitch, cos_pitch  in  16 each  signed Q1.14 values.
- out_valid  out  1  a camera-space vertex is available.
- out_ready  in  1  the downstream stage consumes the vertex.
- vx, vy, vz  out  32 each  camera-space coordinates, signed.
- behind  out  1  set when vz < NEAR; qualified by out_valid.
- vert_count  out  CNT_W  vertices emitted since the last FRAME_START.
- cull_count  out  CNT_W  emitted vertices with behind=1 since the last FRAME_START.

## Operation
- A vertex transfers in when in_valid && in_ready, and transfers out when out_valid && out_ready.
- Camera position and trig inputs are sampled in the same cycle as the vertex and travel with it down the pipeline. Camera changes between vertices therefore take effect per vertex.
- S1 (translate): dx=wx−cam_x, dy=wy−cam_y, dz=wz−cam_z, computed in 32 bits.
- S2 (yaw):
  - x1 = (dx·cos_yaw − dz·sin_yaw) >>> TRIG_FRAC
  - z1 = (dx·sin_yaw + dz·cos_yaw) >>> TRIG_FRAC
  - y1 = dy
- S3 (pitch):
  - vy = (y1·cos_pitch − z1·sin_pitch) >>> TRIG_FRAC
  - vz = (y1·sin_pitch + z1·cos_pitch) >>> TRIG_FRAC
  - vx = x1
  - behind = (vz < NEAR), using a signed compare.
- Arithmetic and width rules:
  - Products are 48-bit signed and sums are 49-bit.
  - The shift is arithmetic (it floors toward −∞).
  - Results truncate to 32 bits with two's-complement wrap.
  - Inputs are guaranteed |coord| < 2^24, so no overflow occurs in legal use.
- Statistics counters:
  - vert_count increments on each output transfer.
  - cull_count increments on each output transfer where behind=1.
  - Both counters saturate at all-ones.
  - FRAME_START clears both. If a transfer coincides with FRAME_START, the counters become 1 (or 0 for cull_count when that vertex is not behind): the clear applies first, then the increment.

## Timing
- Latency is 3 cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 vertex per cycle.
- Pipeline enable: en = !out_valid || out_ready. Stall is global, and in_ready = en (combinational from out_ready).
- Each stage holds a valid bit. When en=0, every stage register and valid bit holds its value, and vx/vy/vz/behind stay stable while out_valid=1.
- Bubbles advance normally: an empty output stage never blocks the pipeline.
- Reset values: all stage valid bits = 0, out_valid = 0, vx = vy = vz = 0, behind = 0, vert_count = cull_count = 0. in_ready = 1 directly after reset.
- Reset asserted mid-operation discards all in-flight vertices immediately (asynchronous). Outputs return to their reset values in the same cycle.

## Structure
- Shared package `gfx_pkg`:
  - typedef `coord_t` (signed 32).
  - typedef `trig_t` (signed 16).
  - struct `vec3_t` {x, y, z}.
  - constant `TRIG_ONE` = 16384.
- Sub-module `rot2d`: a registered 2-D rotation, (a, b, sin, cos, en) → (a·cos − b·sin, a·sin + b·cos) >>> TRIG_FRAC. It is instantiated twice: once for yaw (dx, dz) and once for pitch (y1, z1).

## Test plan
- Identity rotation: camera (0,0,0), cos=16384, sin=0; vertex (100,50,200) → out_valid 3 cycles later with (100,50,200), behind=0.
- Translation only: camera (10,20,30); vertex (10,20,130) → (0,0,100).
- Yaw 90° (sin_yaw=16384, cos_yaw=0, pitch identity) on vertex (100,0,0) → (0,0,100). Repeat with pitch 90° (sin_pitch=16384, cos_pitch=0) on vertex (0,100,0) → vz=100, vy=0.
- Near plane and counters: stream (0,0,0), (0,0,5), (0,0,−3) with identity camera → behind = 1, 0, 1; vert_count=3, cull_count=2. A FRAME_START pulse clears both to 0.
- Backpressure: stream 8 vertices while holding out_ready=0 for 5 cycles after the first out_valid → in_ready drops in that same cycle, outputs stay stable, and all 8 vertices emerge in order with no loss or duplication.
- Reset mid-stream: assert RESET_N=0 with 3 vertices in flight → out_valid=0 and counters=0 immediately. After release, a new vertex emerges after 3 cycles.
